// File: rtl/iob_ram_stream_rd_if.sv
// RAM read port plus output stream bundle for iob_ram_stream_rd.
// master = the stream engine; slave = RAM and stream consumer side.
interface iob_ram_stream_rd_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                  ram_en;
    logic [DATA_W/8-1:0]   ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_din;
    logic [DATA_W-1:0]     ram_dout;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_W-1:0]     m_data;
    logic                  m_last;

    modport master (
        output ram_en, ram_we, ram_addr, ram_din, m_valid, m_data, m_last,
        input  ram_dout, m_ready
    );

    modport slave (
        input  ram_en, ram_we, ram_addr, ram_din, m_valid, m_data, m_last,
        output ram_dout, m_ready
    );
endinterface

// File: rtl/iob_ram_stream_rd.sv
// Streams len consecutive RAM words from base_addr onto a valid/ready stream.
// Define IOB_RAM_STREAM_RD_DOUT_REG_EN for a RAM with registered output (LAT=2, DEPTH=4).
module iob_ram_stream_rd #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    iob_ram_stream_rd_if.master bus
);
`ifdef IOB_RAM_STREAM_RD_DOUT_REG_EN
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
`else
    localparam int LAT   = 1;
    localparam int DEPTH = 3;
`endif
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             stateReg, stateNext;
    logic [ADDR_W-1:0]  baseReg;
    logic [CNT_W-1:0]   lenReg;
    logic [CNT_W-1:0]   issuedCnt;
    logic [CNT_W-1:0]   poppedCnt;
    logic [LAT-1:0]     pipeReg;
    logic [CW-1:0]      occReg;
    logic [CW-1:0]      inFlight;
    logic [PW-1:0]      rdPtr;
    logic [PW-1:0]      wrPtr;
    logic [DATA_W-1:0]  fifoMem [DEPTH];

    logic ramEn;
    logic capture;
    logic mValid;
    logic handshake;
    logic lastWord;

    always_comb begin
        inFlight = '0;
        for (int i = 0; i < LAT; i++) begin
            inFlight = inFlight + CW'(pipeReg[i]);
        end
    end

    // Credit uses the pre-pop occupancy so m_ready never reaches the RAM side.
    assign ramEn     = (stateReg == RUN) && (issuedCnt < lenReg)
                       && ((occReg + inFlight) < CW'(DEPTH));
    assign capture   = pipeReg[LAT-1];
    assign mValid    = (occReg != '0);
    assign handshake = mValid && bus.m_ready;
    assign lastWord  = (poppedCnt + CNT_W'(1)) == lenReg;

    assign bus.ram_en   = ramEn;
    assign bus.ram_addr = baseReg + issuedCnt[ADDR_W-1:0];
    assign bus.ram_we   = '0;
    assign bus.ram_din  = '0;
    assign bus.m_valid  = mValid;
    assign bus.m_data   = mValid ? fifoMem[rdPtr] : '0;
    assign bus.m_last   = mValid && lastWord;

    assign busy = (stateReg != IDLE);
    assign done = (stateReg == FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stateReg <= IDLE;
        else        stateReg <= stateNext;
    end

    // A zero-length request still spends one cycle in RUN, so done lands two cycles after start.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if ((lenReg == '0) || (handshake && lastWord)) stateNext = FIN;
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baseReg   <= '0;
            lenReg    <= '0;
            issuedCnt <= '0;
            poppedCnt <= '0;
            pipeReg   <= '0;
            occReg    <= '0;
            rdPtr     <= '0;
            wrPtr     <= '0;
        end else begin
            pipeReg <= LAT'({pipeReg, ramEn});
            if (stateReg == IDLE) begin
                if (start) begin
                    baseReg   <= base_addr;
                    lenReg    <= len;
                    issuedCnt <= '0;
                    poppedCnt <= '0;
                end
            end else begin
                if (ramEn)     issuedCnt <= issuedCnt + CNT_W'(1);
                if (handshake) poppedCnt <= poppedCnt + CNT_W'(1);
            end
            if (capture) begin
                wrPtr <= (wrPtr == PW'(DEPTH - 1)) ? '0 : wrPtr + PW'(1);
            end
            if (handshake) begin
                rdPtr <= (rdPtr == PW'(DEPTH - 1)) ? '0 : rdPtr + PW'(1);
            end
            occReg <= occReg + CW'(capture) - CW'(handshake);
        end
    end

    always_ff @(posedge clk) begin
        if (capture) fifoMem[wrPtr] <= bus.ram_dout;
    end
endmodule
